// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the boot-time instruction memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      CNT_LO = 3'd0,
      CNT_HI = 3'd1,
      DATA   = 3'd2,
      CSUM   = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_e;

   localparam int COUNT_BYTES = 2;
   localparam int WORD_BYTES  = 4;

   // A frame must carry at least one word and no more than the memory holds.
   function automatic logic count_ok(input logic [8*COUNT_BYTES-1:0] cnt, input int depth);
      return (cnt != '0) && (32'(cnt) <= 32'(depth));
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, program-memory write port and status signals of the loader.
interface imem_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              start;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              core_hold;
   logic              load_done;
   logic              load_err;

   modport master (
      output byte_in, byte_valid, start,
      input  byte_ready, wr_en, wr_addr, wr_data, core_hold, load_done, load_err
   );

   modport slave (
      input  byte_in, byte_valid, start,
      output byte_ready, wr_en, wr_addr, wr_data, core_hold, load_done, load_err
   );
endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted data bytes LSB-first into 32-bit words and keeps the running XOR checksum.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    byte_en_i,
   input  logic [7:0]              byte_i,
   output logic                    word_ready_o,
   output logic [8*WORD_BYTES-1:0] word_o,
   output logic [7:0]              csum_o
);
   localparam int LANE_W = $clog2(WORD_BYTES);

   logic [LANE_W-1:0]       lane_q;
   logic [8*WORD_BYTES-1:0] asm_q, asm_d;
   logic [7:0]              csum_q;

   always_comb begin
      asm_d = asm_q;
      asm_d[{lane_q, 3'b000} +: 8] = byte_i;
   end

   // The word is presented combinationally with its last byte so the top can register the write.
   assign word_ready_o = byte_en_i && (lane_q == LANE_W'(WORD_BYTES - 1));
   assign word_o       = asm_d;
   assign csum_o       = csum_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lane_q <= '0;
         asm_q  <= '0;
         csum_q <= '0;
      end else if (clear_i) begin
         lane_q <= '0;
         asm_q  <= '0;
         csum_q <= '0;
      end else if (byte_en_i) begin
         lane_q <= lane_q + 1'b1;
         asm_q  <= asm_d;
         csum_q <= csum_q ^ byte_i;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses count/data/checksum frames, writes program memory and holds the core until a good load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
)(
   input logic         clk,
   input logic         rst,
   imem_loader_if.slave bus
);
   state_e                   state_q;
   logic [8*COUNT_BYTES-1:0] count_q;
   logic [ADDR_W:0]          word_idx_q;
   logic [ADDR_W:0]          word_idx_d;
   logic                     wr_en_q;
   logic [ADDR_W-1:0]        wr_addr_q;
   logic [31:0]              wr_data_q;
   logic                     core_hold_q;
   logic                     load_done_q;
   logic                     load_err_q;

   logic                     accept;
   logic                     rx_state;
   logic [8*COUNT_BYTES-1:0] count_d;
   logic                     last_word;
   logic                     word_ready;
   logic [31:0]              word;
   logic [7:0]               csum;

   assign rx_state = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                     (state_q == DATA)   || (state_q == CSUM);
   assign bus.byte_ready = rst && rx_state;
   assign accept         = bus.byte_valid && bus.byte_ready;

   assign count_d    = {bus.byte_in, count_q[7:0]};
   assign word_idx_d = word_idx_q + 1'b1;
   // word_idx carries one extra bit so a full-depth frame ends without wrapping.
   assign last_word  = (32'(word_idx_d) == 32'(count_q));

   imem_word_packer u_packer (
      .clk_i        (clk),
      .rst_ni       (rst),
      .clear_i      ((state_q == CNT_HI) && accept),
      .byte_en_i    ((state_q == DATA) && accept),
      .byte_i       (bus.byte_in),
      .word_ready_o (word_ready),
      .word_o       (word),
      .csum_o       (csum)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= CNT_LO;
         count_q     <= '0;
         word_idx_q  <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         core_hold_q <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            CNT_LO: begin
               if (accept) begin
                  count_q[7:0] <= bus.byte_in;
                  state_q      <= CNT_HI;
               end
            end
            CNT_HI: begin
               if (accept) begin
                  count_q <= count_d;
                  if (count_ok(count_d, DEPTH)) begin
                     word_idx_q <= '0;
                     state_q    <= DATA;
                  end else begin
                     load_err_q <= 1'b1;
                     state_q    <= ERR;
                  end
               end
            end
            DATA: begin
               if (word_ready) begin
                  wr_en_q    <= 1'b1;
                  wr_addr_q  <= word_idx_q[ADDR_W-1:0];
                  wr_data_q  <= word;
                  word_idx_q <= word_idx_d;
                  if (last_word) begin
                     state_q <= CSUM;
                  end
               end
            end
            CSUM: begin
               if (accept) begin
                  if (bus.byte_in == csum) begin
                     load_done_q <= 1'b1;
                     core_hold_q <= 1'b0;
                     state_q     <= DONE;
                  end else begin
                     load_err_q <= 1'b1;
                     state_q    <= ERR;
                  end
               end
            end
            DONE: begin
               if (bus.start) begin
                  load_done_q <= 1'b0;
                  core_hold_q <= 1'b1;
                  state_q     <= CNT_LO;
               end
            end
            ERR: begin
               if (bus.start) begin
                  load_err_q <= 1'b0;
                  state_q    <= CNT_LO;
               end
            end
            default: begin
               state_q <= CNT_LO;
            end
         endcase
      end
   end

   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.core_hold = core_hold_q;
   assign bus.load_done = load_done_q;
   assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: frames are built from word lists and checked against a word-level model.
module tb_imem_loader;

   logic clk = 1'b0;
   logic rst = 1'b0;

   imem_loader_if #(.ADDR_W(10)) bus();

   imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int          acc_cyc[$];
   int          wr_cyc[$];
   logic [9:0]  wr_a[$];
   logic [31:0] wr_d[$];

   always @(posedge clk) begin
      cyc++;
      if (bus.byte_valid && bus.byte_ready) acc_cyc.push_back(cyc);
      if (bus.wr_en) begin
         wr_cyc.push_back(cyc);
         wr_a.push_back(bus.wr_addr);
         wr_d.push_back(bus.wr_data);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Reference: checksum is the XOR of every data byte, i.e. the byte-fold of the XOR of all words.
   function automatic logic [7:0] model_csum(input logic [31:0] w[$]);
      logic [31:0] x;
      x = 32'h0;
      foreach (w[i]) x = x ^ w[i];
      return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
   endfunction

   task automatic clear_logs();
      acc_cyc.delete();
      wr_cyc.delete();
      wr_a.delete();
      wr_d.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
      bit ok;
      bus.byte_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk);
         #1;
      end
      bus.start      = 1'b0;
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
         if (bus.byte_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.byte_valid = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL handshake_timeout byte=%02h got=no_accept exp=accept", b);
      end
   endtask

   task automatic send_frame(input logic [15:0] cnt, input logic [31:0] w[$],
                             input logic [7:0] cs, input int maxgap);
      send_byte(cnt[7:0], 0, 1'b0);
      send_byte(cnt[15:8], $urandom_range(0, maxgap), maxgap > 0);
      foreach (w[i]) begin
         for (int k = 0; k < 4; k++) begin
            send_byte(8'(w[i] >> (8 * k)), $urandom_range(0, maxgap), maxgap > 0);
         end
      end
      send_byte(cs, $urandom_range(0, maxgap), maxgap > 0);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.byte_in = 8'h00;
      bus.byte_valid = 1'b1;
      bus.start = 1'b0;
      idle(3);
      total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL rst_byte_ready got=%b exp=0", bus.byte_ready); end
      total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", bus.wr_en); end
      total++; if (bus.wr_addr !== 10'd0) begin bad++; $display("FAIL rst_wr_addr got=%0h exp=0", bus.wr_addr); end
      total++; if (bus.wr_data !== 32'd0) begin bad++; $display("FAIL rst_wr_data got=%0h exp=0", bus.wr_data); end
      total++; if (bus.core_hold !== 1'b1) begin bad++; $display("FAIL rst_core_hold got=%b exp=1", bus.core_hold); end
      total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL rst_load_done got=%b exp=0", bus.load_done); end
      total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL rst_load_err got=%b exp=0", bus.load_err); end
      bus.byte_valid = 1'b0;
      rst = 1'b1;
      #1;
      total++; if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL rel_byte_ready got=%b exp=1", bus.byte_ready); end
      idle(1);
   endtask

   task automatic test_good_frame();
      logic [31:0] w[$];
      w = '{32'h00100093, 32'h00200113};
      clear_logs();
      send_frame(16'd2, w, model_csum(w), 0);
      idle(2);
      total++; if (wr_a.size() !== 2) begin bad++; $display("FAIL good_wr_count got=%0d exp=2", wr_a.size()); end
      for (int i = 0; i < wr_a.size() && i < 2; i++) begin
         total++; if (wr_a[i] !== 10'(i)) begin bad++; $display("FAIL good_addr[%0d] got=%0h exp=%0h", i, wr_a[i], i); end
         total++; if (wr_d[i] !== w[i]) begin bad++; $display("FAIL good_data[%0d] got=%08h exp=%08h", i, wr_d[i], w[i]); end
         if (acc_cyc.size() > 5 + 4 * i) begin
            total++; if (wr_cyc[i] !== acc_cyc[5 + 4 * i] + 1) begin bad++; $display("FAIL good_latency[%0d] got=%0d exp=%0d", i, wr_cyc[i], acc_cyc[5 + 4 * i] + 1); end
         end
      end
      total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL good_load_done got=%b exp=1", bus.load_done); end
      total++; if (bus.core_hold !== 1'b0) begin bad++; $display("FAIL good_core_hold got=%b exp=0", bus.core_hold); end
      total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL good_load_err got=%b exp=0", bus.load_err); end
      total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL good_byte_ready got=%b exp=0", bus.byte_ready); end
      pulse_start();
      total++; if (bus.core_hold !== 1'b1) begin bad++; $display("FAIL restart_core_hold got=%b exp=1", bus.core_hold); end
      total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL restart_load_done got=%b exp=0", bus.load_done); end
      total++; if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL restart_byte_ready got=%b exp=1", bus.byte_ready); end
   endtask

   task automatic test_bad_csum();
      logic [31:0] w[$];
      w = '{32'h00100093, 32'h00200113};
      clear_logs();
      // Correct checksum of these bytes is 0xB1, so 0x23 must be rejected.
      send_frame(16'd2, w, 8'h23, 0);
      idle(2);
      total++; if (wr_a.size() !== 2) begin bad++; $display("FAIL badcs_wr_count got=%0d exp=2", wr_a.size()); end
      for (int i = 0; i < wr_a.size() && i < 2; i++) begin
         total++; if (wr_d[i] !== w[i] || wr_a[i] !== 10'(i)) begin bad++; $display("FAIL badcs_write[%0d] got=%0h:%08h exp=%0h:%08h", i, wr_a[i], wr_d[i], i, w[i]); end
      end
      total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL badcs_load_err got=%b exp=1", bus.load_err); end
      total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL badcs_load_done got=%b exp=0", bus.load_done); end
      total++; if (bus.core_hold !== 1'b1) begin bad++; $display("FAIL badcs_core_hold got=%b exp=1", bus.core_hold); end
      total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL badcs_byte_ready got=%b exp=0", bus.byte_ready); end
      pulse_start();
      total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL badcs_restart_err got=%b exp=0", bus.load_err); end
      total++; if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL badcs_restart_ready got=%b exp=1", bus.byte_ready); end
      total++; if (bus.core_hold !== 1'b1) begin bad++; $display("FAIL badcs_restart_hold got=%b exp=1", bus.core_hold); end
   endtask

   task automatic test_bad_count();
      logic [15:0] cnts[3];
      cnts[0] = 16'd0;
      cnts[1] = 16'd1025;
      cnts[2] = 16'($urandom_range(1026, 65535));
      for (int c = 0; c < 3; c++) begin
         clear_logs();
         send_byte(cnts[c][7:0], 0, 1'b0);
         send_byte(cnts[c][15:8], 0, 1'b0);
         total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL badcnt_err[%0d] got=%b exp=1", cnts[c], bus.load_err); end
         bus.byte_in = 8'h5A;
         bus.byte_valid = 1'b1;
         idle(3);
         bus.byte_valid = 1'b0;
         total++; if (acc_cyc.size() !== 2) begin bad++; $display("FAIL badcnt_accepts[%0d] got=%0d exp=2", cnts[c], acc_cyc.size()); end
         total++; if (wr_a.size() !== 0) begin bad++; $display("FAIL badcnt_writes[%0d] got=%0d exp=0", cnts[c], wr_a.size()); end
         total++; if (bus.core_hold !== 1'b1) begin bad++; $display("FAIL badcnt_hold[%0d] got=%b exp=1", cnts[c], bus.core_hold); end
         pulse_start();
      end
   endtask

   task automatic test_gaps();
      logic [31:0] w[$];
      int n;
      for (int it = 0; it < 6; it++) begin
         n = (it == 0) ? 1 : int'($urandom_range(1, 4));
         w.delete();
         for (int i = 0; i < n; i++) w.push_back($urandom);
         clear_logs();
         send_frame(16'(n), w, model_csum(w), 5);
         idle(2);
         total++; if (wr_a.size() !== n) begin bad++; $display("FAIL gap_wr_count[%0d] got=%0d exp=%0d", it, wr_a.size(), n); end
         for (int i = 0; i < wr_a.size() && i < n; i++) begin
            total++; if (wr_a[i] !== 10'(i) || wr_d[i] !== w[i]) begin bad++; $display("FAIL gap_write[%0d.%0d] got=%0h:%08h exp=%0h:%08h", it, i, wr_a[i], wr_d[i], i, w[i]); end
            if (acc_cyc.size() > 5 + 4 * i) begin
               total++; if (wr_cyc[i] !== acc_cyc[5 + 4 * i] + 1) begin bad++; $display("FAIL gap_latency[%0d.%0d] got=%0d exp=%0d", it, i, wr_cyc[i], acc_cyc[5 + 4 * i] + 1); end
            end
         end
         total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL gap_done[%0d] got=%b exp=1", it, bus.load_done); end
         pulse_start();
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] w[$];
      w = '{$urandom};
      clear_logs();
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(w[0][7:0], 0, 1'b0);
      send_byte(w[0][15:8], 0, 1'b0);
      #2 rst = 1'b0;
      #1;
      total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", bus.byte_ready); end
      total++; if (bus.core_hold !== 1'b1) begin bad++; $display("FAIL midrst_hold got=%b exp=1", bus.core_hold); end
      @(posedge clk);
      #1 rst = 1'b1;
      idle(3);
      total++; if (wr_a.size() !== 0) begin bad++; $display("FAIL midrst_writes got=%0d exp=0", wr_a.size()); end
      total++; if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL midrst_cnt_lo got=%b exp=1", bus.byte_ready); end
      total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", bus.load_done); end
      w = '{$urandom};
      clear_logs();
      send_frame(16'd1, w, model_csum(w), 0);
      idle(2);
      total++; if (wr_a.size() !== 1) begin bad++; $display("FAIL fresh_wr_count got=%0d exp=1", wr_a.size()); end
      if (wr_a.size() > 0) begin
         total++; if (wr_a[0] !== 10'd0 || wr_d[0] !== w[0]) begin bad++; $display("FAIL fresh_write got=%0h:%08h exp=0:%08h", wr_a[0], wr_d[0], w[0]); end
      end
      total++; if (bus.load_done !== 1'b1 || bus.core_hold !== 1'b0) begin bad++; $display("FAIL fresh_status got=%b%b exp=10", bus.load_done, bus.core_hold); end
      pulse_start();
   endtask

   task automatic test_full_depth();
      logic [31:0] w[$];
      int errs;
      for (int i = 0; i < 1024; i++) w.push_back(32'(i));
      clear_logs();
      send_frame(16'd1024, w, model_csum(w), 0);
      idle(2);
      total++; if (wr_a.size() !== 1024) begin bad++; $display("FAIL full_wr_count got=%0d exp=1024", wr_a.size()); end
      errs = 0;
      for (int i = 0; i < wr_a.size(); i++) begin
         total++;
         if (i >= 1024 || wr_a[i] !== 10'(i) || wr_d[i] !== 32'(i)) begin
            bad++;
            if (errs < 5) $display("FAIL full_write[%0d] got=%0h:%08h exp=%0h:%08h", i, wr_a[i], wr_d[i], i, i);
            errs++;
         end
      end
      if (wr_a.size() > 0) begin
         total++; if (wr_a[wr_a.size() - 1] !== 10'd1023 || wr_d[wr_d.size() - 1] !== 32'h3FF) begin bad++; $display("FAIL full_last got=%0h:%08h exp=3ff:000003ff", wr_a[wr_a.size() - 1], wr_d[wr_d.size() - 1]); end
      end
      total++; if (bus.load_done !== 1'b1 || bus.core_hold !== 1'b0) begin bad++; $display("FAIL full_status got=%b%b exp=10", bus.load_done, bus.core_hold); end
   endtask

   initial begin
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      bus.start      = 1'b0;
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_bad_count();
      test_gaps();
      test_mid_reset();
      test_full_depth();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
